multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I-subset datapath (PC, IR, register file, ALU, unified instruction/data memory). Each instruction is stepped through fetch, decode, execute, memory and writeback states. The block drives every datapath mux select and write strobe, and decodes `alu_control`. Memory access uses a req/ready handshake with a timeout. It also counts retired instructions.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: consecutive wait cycles with `mem_ready` low before a bus-error trap (≥1).
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7_5` in 1: IR[30].
- `zero` in 1: ALU zero flag, combinational from the current ALU result.
- `mem_ready` in 1: memory completes the transfer in this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write (store) request.
- `iord` out 1: address select; 0 = PC, 1 = ALUOut.
- `ir_we` out 1: IR load strobe.
- `pc_we` out 1: PC load strobe.
- `pc_src` out 1: PC source; 0 = ALU result, 1 = ALUOut.
- `rf_we` out 1: register-file write strobe.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_control` out 4: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- `result_src` out 2: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `beq` out 1: one-cycle pulse when a conditional branch is taken.
- `halted` out 1: core stopped in TRAP.
- `err` out 1: trap was caused by an error.
- `retired` out CNT_W: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP.
- Reset is sampled at a `clk` edge with `reset`=0. The next state is IDLE and `retired`, `err`, `halted` and the timeout counter are cleared. In IDLE all strobes are 0 and all selects are 00/0. IDLE moves to FETCH on the first edge with `reset`=1.
- **FETCH**
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=10, ADD.
  - In the cycle `mem_ready`=1 it also drives `ir_we`=1, `pc_we`=1, `pc_src`=0, then moves to DECODE.
- **DECODE**
  - Computes the branch/jump target: oldPC + imm, ADD, latched into ALUOut.
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL.
  - 1110011 → TRAP with `halted`. Any other opcode → TRAP with `err`.
- **MEMADR**: rs1 + imm. Load opcode → MEMREAD, store opcode → MEMWRITE.
- **MEMREAD**: `mem_req`=1, `iord`=1; waits for `mem_ready`, then → MEMWB.
- **MEMWB**: `rf_we`=1, `result_src`=01 → FETCH.
- **MEMWRITE**: `mem_req`=1, `mem_we`=1, `iord`=1; waits for `mem_ready`, then → FETCH.
- **EXEC_R**: rs1 op rs2, `alu_control` decoded from `funct3`/`funct7_5` → ALUWB.
- **EXEC_I**: rs1 op imm → ALUWB. `funct7_5` is honoured only when `funct3`=101 (SRAI vs SRLI); it is ignored for ADDI.
- **ALUWB**: `rf_we`=1, `result_src`=00 → FETCH.
- **BRANCH**
  - rs1 − rs2 (SUB). Taken when `funct3`=000 and `zero`=1 (BEQ), or `funct3`=001 and `zero`=0 (BNE).
  - Taken: `pc_we`=1, `pc_src`=1, `beq`=1, then → FETCH. Not taken: → FETCH with no strobes.
  - Any other `funct3` → TRAP with `err`.
- **JAL**: oldPC + 4 (ALU), `rf_we`=1, `result_src`=10, `pc_we`=1, `pc_src`=1 → FETCH.
- **TRAP**: terminal until reset. All strobes 0, `halted`=1, `err` held.
- Memory handshake:
  - `mem_req`, `mem_we` and `iord` are held stable until the cycle with `mem_ready`=1.
  - `mem_ready` is ignored whenever `mem_req`=0.
- Timeout:
  - The counter increments on each wait cycle with `mem_ready`=0 and is cleared on handshake completion or on leaving the state.
  - When it reaches `MEM_TIMEOUT`, the next state is TRAP with `err`=1.
- Retired counter:
  - `retired` increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or JAL.
  - It wraps modulo 2^CNT_W.

## Timing
- Strobes are Mealy: combinational from the current state plus `mem_ready`/`zero`. State and counters are registered.
- Minimum latency with `mem_ready` high in the first request cycle:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / JAL: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset low mid-transaction: IDLE on the next edge and `mem_req` drops. The memory abandons the transfer.
- Reset has priority over trap entry, timeout and handshake completion in the same cycle.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - ALU control codes;
  - the `alu_src_a`, `alu_src_b`, `result_src` and `pc_src` encodings.
- Sub-module `riscv_alu_decoder` is purely combinational. It maps (state class R/I/ADD/SUB, `funct3`, `funct7_5`) to `alu_control`.

## Test plan
1. **ADDI x1,x0,5 (0x00500093)**, `mem_ready` always 1, after reset release.
   - Sequence IDLE→FETCH→DECODE→EXEC_I→ALUWB.
   - `rf_we`=1 in ALUWB, `alu_control`=0000, `retired`=1.
2. **R-type opcodes**:
   - SUB x2,x1,x2 (0x40208133) → EXEC_R `alu_control`=0001.
   - SRA (funct3 101, funct7_5 1) → 0111.
   - ADDI with IR[30]=1 → 0000.
3. **BEQ x0,x0,8 (0x00000463)**:
   - `zero`=1 in BRANCH → `pc_we`=1, `pc_src`=1, `beq`=1 for exactly 1 cycle.
   - `zero`=0 → no strobes. `retired` increments in both cases.
4. **LW** with `mem_ready` delayed 3 cycles in MEMREAD:
   - `mem_req`/`iord`=1 held for 4 cycles, then MEMWB `rf_we`=1 with `result_src`=01.
   - Total 8 cycles.
5. **Traps**:
   - `MEM_TIMEOUT`=4 with `mem_ready` stuck 0 in FETCH → TRAP after 4 wait cycles, `err`=1, `halted`=1, `mem_req`=0.
   - Opcode 0x00 → `err`=1.
   - ECALL 0x00000073 → `halted`=1, `err`=0.
6. **Reset during a MEMWRITE wait** → IDLE next cycle; `mem_req`=0, `mem_we`=0, `retired`=0, `err`=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared states, opcodes and select encodings for the multi-cycle controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  // Which flavour of ALU operation the current state asks the decoder for
  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_R,
    ALU_CLS_I
  } alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/riscv_alu_decoder.sv
// rtl/riscv_alu_decoder.sv - combinational ALU operation decode from state class and funct fields
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_cls_t   alu_cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  logic alt;

  // IR[30] selects SUB only for register ops; shifts honour it for both R and I
  assign alt = funct7_5;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_cls)
      ALU_CLS_ADD: alu_control = ALU_ADD;
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_R, ALU_CLS_I: begin
        case (funct3)
          3'b000:  alu_control = (alu_cls == ALU_CLS_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I-subset control sequencer with memory timeout and retire counter
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic [1:0]       result_src,
  output logic             beq,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           state, state_nx;
  alu_cls_t         alu_cls;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             err_q;
  logic             mem_wait;
  logic             err_set;
  logic             retire;

  riscv_alu_decoder u_alu_dec (
    .alu_cls     (alu_cls),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (alu_control)
  );

  always_comb begin
    state_nx   = state;
    alu_cls    = ALU_CLS_ADD;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    rf_we      = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    beq        = 1'b0;
    mem_wait   = 1'b0;
    err_set    = 1'b0;
    retire     = 1'b0;

    case (state)
      S_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we    = 1'b1;
          pc_we    = 1'b1;
          pc_src   = PC_SRC_ALU;
          state_nx = S_DECODE;
        end else begin
          mem_wait = 1'b1;
        end
      end

      // Branch/jump target is formed here so BRANCH and JAL can load PC from ALUOut
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_RTYPE:          state_nx = S_EXEC_R;
          OP_ITYPE:          state_nx = S_EXEC_I;
          OP_BRANCH:         state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          OP_SYSTEM:         state_nx = S_TRAP;
          default: begin
            state_nx = S_TRAP;
            err_set  = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_nx  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
        else           mem_wait = 1'b1;
      end

      S_MEMWB: begin
        rf_we      = 1'b1;
        result_src = RES_MEM;
        state_nx   = S_FETCH;
        retire     = 1'b1;
      end

      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
        end else begin
          mem_wait = 1'b1;
        end
      end

      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_cls   = ALU_CLS_R;
        state_nx  = S_ALUWB;
      end

      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_cls   = ALU_CLS_I;
        state_nx  = S_ALUWB;
      end

      S_ALUWB: begin
        rf_we      = 1'b1;
        result_src = RES_ALUOUT;
        state_nx   = S_FETCH;
        retire     = 1'b1;
      end

      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_cls   = ALU_CLS_SUB;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          state_nx = S_FETCH;
          retire   = 1'b1;
          if ((funct3 == 3'b000) == zero) begin
            pc_we  = 1'b1;
            pc_src = PC_SRC_ALUOUT;
            beq    = 1'b1;
          end
        end else begin
          state_nx = S_TRAP;
          err_set  = 1'b1;
        end
      end

      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        rf_we      = 1'b1;
        result_src = RES_ALU;
        pc_we      = 1'b1;
        pc_src     = PC_SRC_ALUOUT;
        state_nx   = S_FETCH;
        retire     = 1'b1;
      end

      S_TRAP: state_nx = S_TRAP;

      default: state_nx = S_IDLE;
    endcase

    // The last tolerated wait cycle overrides whatever the state wanted next
    if (mem_wait && to_cnt == TO_LAST) begin
      state_nx = S_TRAP;
      err_set  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_nx;
      if (mem_wait && state_nx == state) to_cnt <= to_cnt + 1'b1;
      else                               to_cnt <= '0;
      if (err_set) err_q <= 1'b1;
      if (retire)  retired_q <= retired_q + 1'b1;
    end
  end

  assign halted  = (state == S_TRAP);
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic [2:0]    funct3 = 3'd0;
  logic          funct7_5 = 1'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          mem_req, mem_we, iord, ir_we, pc_we, pc_src, rf_we;
  logic [1:0]    alu_src_a, alu_src_b, result_src;
  logic [3:0]    alu_control;
  logic          beq, halted, err;
  logic [CW-1:0] retired;

  int n_chk = 0;
  int n_err = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src), .beq(beq),
    .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         waits;
    logic [3:0] e_alu;
    int         e_cyc;
    int         e_rf;
    int         e_pc;
    int         e_beq;
    logic [1:0] e_rs;
    int         e_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic f7, logic z, int waits,
                              logic [3:0] e_alu, int e_cyc, int e_rf, int e_pc, int e_beq,
                              logic [1:0] e_rs, int e_dat);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.waits = waits;
    v.e_alu = e_alu; v.e_cyc = e_cyc; v.e_rf = e_rf; v.e_pc = e_pc;
    v.e_beq = e_beq; v.e_rs = e_rs; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle after release
  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    exp_ret = 0;
    @(negedge clk);
    check("rst_strobes", {mem_req, mem_we, iord, ir_we, pc_we, pc_src, rf_we, beq}, 0);
    check("rst_selects", {alu_src_a, alu_src_b, result_src}, 0);
    check("rst_flags", {halted, err}, 0);
    check("rst_retired", 32'(retired), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_fetch", {mem_req, iord}, 2'b10);
  endtask

  task automatic run_instr(input vec_t v, input int idx);
    int cyc, rf, pc, bq, dat;
    logic [3:0] alu;
    logic [1:0] rs;
    bit done;
    opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; zero = v.z; mem_ready = 1'b1;
    cyc = 1; rf = 0; pc = 0; bq = 0; dat = 0; alu = '0; rs = '0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (mem_req && !iord) begin
        done = 1;
      end else begin
        cyc++;
        if (cyc == 3) alu = alu_control;
        rf += int'(rf_we);
        pc += int'(pc_we);
        bq += int'(beq);
        if (rf_we) rs = result_src;
        if (mem_req && iord) begin
          dat++;
          mem_ready = (dat == v.waits + 1);
        end
      end
    end
    exp_ret++;
    check($sformatf("v%0d_done", idx), 32'(done), 1);
    check($sformatf("v%0d_cyc", idx), cyc, v.e_cyc);
    check($sformatf("v%0d_alu", idx), 32'(alu), 32'(v.e_alu));
    check($sformatf("v%0d_rf_we", idx), rf, v.e_rf);
    check($sformatf("v%0d_pc_we", idx), pc, v.e_pc);
    check($sformatf("v%0d_beq", idx), bq, v.e_beq);
    check($sformatf("v%0d_res_src", idx), 32'(rs), 32'(v.e_rs));
    check($sformatf("v%0d_mem_cyc", idx), dat, v.e_dat);
    check($sformatf("v%0d_retired", idx), 32'(retired), exp_ret);
  endtask

  task automatic run_trap(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input int e_cyc, input logic e_err);
    int cyc;
    do_reset();
    opcode = op; funct3 = f3; funct7_5 = 1'b0; zero = 1'b0;
    cyc = 1;
    while (!halted && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_cyc"}, cyc, e_cyc);
    check({name, "_err"}, 32'(err), 32'(e_err));
    repeat (3) @(negedge clk);
    check({name, "_sticky"}, {halted, mem_req, pc_we, rf_we, ir_we}, 5'b10000);
    check({name, "_retired"}, 32'(retired), 0);
  endtask

  initial begin
    int n;
    // op, f3, f7, zero, waits | alu, cycles, rf_we, pc_we, beq, result_src, mem cycles
    vecs.push_back(mk(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 4'b0000, 4, 1, 0, 0, 2'b00, 0)); // ADDI
    vecs.push_back(mk(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 4'b0001, 4, 1, 0, 0, 2'b00, 0)); // SUB
    vecs.push_back(mk(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 4'b0111, 4, 1, 0, 0, 2'b00, 0)); // SRA
    vecs.push_back(mk(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 4'b0000, 4, 1, 0, 0, 2'b00, 0)); // ADDI IR30
    vecs.push_back(mk(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 4'b0000, 4, 1, 0, 0, 2'b00, 0)); // ADD
    vecs.push_back(mk(7'b0110011, 3'b101, 1'b0, 1'b0, 0, 4'b0110, 4, 1, 0, 0, 2'b00, 0)); // SRL
    vecs.push_back(mk(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 4'b0111, 4, 1, 0, 0, 2'b00, 0)); // SRAI
    vecs.push_back(mk(7'b0010011, 3'b101, 1'b0, 1'b0, 0, 4'b0110, 4, 1, 0, 0, 2'b00, 0)); // SRLI
    vecs.push_back(mk(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 4'b0101, 4, 1, 0, 0, 2'b00, 0)); // SLL
    vecs.push_back(mk(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 4'b1000, 4, 1, 0, 0, 2'b00, 0)); // SLT
    vecs.push_back(mk(7'b0010011, 3'b011, 1'b0, 1'b0, 0, 4'b1001, 4, 1, 0, 0, 2'b00, 0)); // SLTIU
    vecs.push_back(mk(7'b0110011, 3'b100, 1'b0, 1'b0, 0, 4'b0100, 4, 1, 0, 0, 2'b00, 0)); // XOR
    vecs.push_back(mk(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 4'b0011, 4, 1, 0, 0, 2'b00, 0)); // OR
    vecs.push_back(mk(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 4'b0010, 4, 1, 0, 0, 2'b00, 0)); // ANDI
    vecs.push_back(mk(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 4'b0001, 3, 0, 1, 1, 2'b00, 0)); // BEQ taken
    vecs.push_back(mk(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 4'b0001, 3, 0, 0, 0, 2'b00, 0)); // BEQ not
    vecs.push_back(mk(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 4'b0001, 3, 0, 1, 1, 2'b00, 0)); // BNE taken
    vecs.push_back(mk(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 4'b0001, 3, 0, 0, 0, 2'b00, 0)); // BNE not
    vecs.push_back(mk(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 4'b0000, 3, 1, 1, 0, 2'b10, 0)); // JAL
    vecs.push_back(mk(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 4'b0000, 5, 1, 0, 0, 2'b01, 1)); // LW
    vecs.push_back(mk(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 4'b0000, 8, 1, 0, 0, 2'b01, 4)); // LW 3 waits
    vecs.push_back(mk(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 4'b0000, 4, 0, 0, 0, 2'b00, 1)); // SW
    vecs.push_back(mk(7'b0100011, 3'b010, 1'b0, 1'b0, 2, 4'b0000, 6, 0, 0, 0, 2'b00, 3)); // SW 2 waits
    vecs.push_back(mk(7'b0100011, 3'b010, 1'b0, 1'b0, 3, 4'b0000, 7, 0, 0, 0, 2'b00, 4)); // SW 3 waits

    do_reset();
    for (int i = 0; i < vecs.size(); i++) run_instr(vecs[i], i);

    // Reset during a store wait, asserted together with mem_ready to test priority
    opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    n = 0;
    while (!mem_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sw_reached", 32'(mem_we), 1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_hold", {mem_req, mem_we, iord}, 3'b111);
    check("sw_pre_retired", 32'(retired), vecs.size());
    do_reset();

    // Fetch never completes: four wait cycles then bus-error trap
    mem_ready = 1'b0;
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (!mem_req) break;
      n++;
    end
    check("to_waits", n, 4);
    check("to_flags", {halted, err, mem_req}, 3'b110);
    check("to_retired", 32'(retired), 0);

    run_trap("bad_op", 7'b0000000, 3'b000, 3, 1'b1);
    run_trap("ecall", 7'b1110011, 3'b000, 3, 1'b0);
    run_trap("bad_br", 7'b1100011, 3'b010, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "bench did not finish");
  end

endmodule
